// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Brings up the board PLL (25 MHz in, 50/25/50 MHz out) from the free-running
//   25 MHz board clock. It pulses the PLL reset, waits for a stable synchronised
//   lock within a timeout and a bounded number of attempts, then releases the
//   three output-domain resets in a staggered order. A lock loss during release
//   or at run time re-initialises the PLL and is counted.
//
// Ports
//   clock       25 MHz free-running board clock, rising edge
//   reset_n     synchronous active-low reset
//   pll_locked  raw PLL LOCK, asynchronous to clock
//   sw_reinit   one-cycle pulse, forces re-initialisation from any state
//   pll_rst     PLL reset request, active-high
//   dom_rst_n   per-domain active-low resets: [0]=clkout0 [1]=clkout1 [2]=clkout2
//   ready       all domains released and lock healthy
//   fail        lock attempts exhausted
//   retries     failed attempts in the current bring-up, saturating at 7
//   lost_cnt    run-time lock losses, saturating at all-ones
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGGER       = 8,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             sw_reinit,
    output logic             pll_rst,
    output logic [2:0]       dom_rst_n,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       retries,
    output logic [CNT_W-1:0] lost_cnt
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared timer covers every timed state; size it for the longest span.
    localparam int TMAX = imax(imax(RST_CYCLES, LOCK_TIMEOUT),
                               imax(STABLE_CYCLES, 3 * STAGGER));
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STAB_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] REL_LAST  = TW'(3 * STAGGER - 1);
    localparam logic [TW-1:0] REL_DOM1  = TW'(STAGGER);
    localparam logic [TW-1:0] REL_DOM2  = TW'(2 * STAGGER);

    typedef enum logic [2:0] {
        ST_PRST,
        ST_WAIT,
        ST_STAB,
        ST_REL,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx;
    logic [2:0]       retries_nx, retry_inc;
    logic [CNT_W-1:0] lost_nx;
    logic             pll_rst_nx, ready_nx, fail_nx;
    logic [2:0]       dom_nx;

    // Two-flop synchroniser for the asynchronous lock; deliberately not reset.
    logic sync_1, locked_s;

    always_ff @(posedge clock) begin
        sync_1   <= pll_locked;
        locked_s <= sync_1;
    end

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        retries_nx = retries;
        lost_nx    = lost_cnt;
        retry_inc  = (retries == 3'd7) ? 3'd7 : retries + 3'd1;

        if (sw_reinit) begin
            // Takes priority over a coincident lock loss, so no loss is counted.
            state_nx   = ST_PRST;
            timer_nx   = '0;
            retries_nx = '0;
        end else begin
            case (state)
                ST_PRST: begin
                    if (timer == RST_LAST) begin
                        state_nx = ST_WAIT;
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
                ST_WAIT: begin
                    // Lock is checked first so it wins over a same-cycle timeout.
                    if (locked_s) begin
                        state_nx = ST_STAB;
                        timer_nx = '0;
                    end else if (timer == TO_LAST) begin
                        retries_nx = retry_inc;
                        timer_nx   = '0;
                        state_nx   = (int'(retry_inc) == MAX_RETRIES) ? ST_FAIL : ST_PRST;
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
                ST_STAB: begin
                    if (!locked_s) begin
                        state_nx = ST_WAIT;
                        timer_nx = '0;
                    end else if (timer == STAB_LAST) begin
                        state_nx = ST_REL;
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer + TW'(1);
                    end
                end
                ST_REL, ST_RUN: begin
                    if (!locked_s) begin
                        state_nx   = ST_PRST;
                        timer_nx   = '0;
                        retries_nx = '0;
                        lost_nx    = (lost_cnt == '1) ? lost_cnt : lost_cnt + CNT_W'(1);
                    end else if (state == ST_REL) begin
                        if (timer == REL_LAST) begin
                            state_nx = ST_RUN;
                            timer_nx = '0;
                        end else begin
                            timer_nx = timer + TW'(1);
                        end
                    end
                end
                ST_FAIL: begin
                    state_nx = ST_FAIL;
                end
                default: begin
                    state_nx = ST_PRST;
                    timer_nx = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state/timer so they register in
        // step with the state they belong to.
        pll_rst_nx = (state_nx == ST_PRST);
        ready_nx   = (state_nx == ST_RUN);
        fail_nx    = (state_nx == ST_FAIL);
        case (state_nx)
            ST_REL:  dom_nx = {timer_nx >= REL_DOM2, timer_nx >= REL_DOM1, 1'b1};
            ST_RUN:  dom_nx = '1;
            default: dom_nx = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_PRST;
            timer     <= '0;
            retries   <= '0;
            lost_cnt  <= '0;
            pll_rst   <= 1'b1;
            dom_rst_n <= '0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            retries   <= retries_nx;
            lost_cnt  <= lost_nx;
            pll_rst   <= pll_rst_nx;
            dom_rst_n <= dom_nx;
            ready     <= ready_nx;
            fail      <= fail_nx;
        end
    end

endmodule
